muldiv_issue_ctrl: RTL and testbench

//  Initiator side of the HI/LO multiply/divide unit interface. Sits beside EX: accepts

---
 rtl/muldiv_issue_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue_ctrl.sv
// HI/LO multiply/divide issue controller: registers commands to the mul/div unit,
// stalls the front pipeline while an op is in flight, and checks busy timing.
//
//  state      | meaning
//  S_IDLE     | ready; accepts any HI/LO op, serves mfhi/mflo directly
//  S_MT       | mthi/mtlo write pulse is out; unit writes HI/LO at end of this cycle
//  S_MD_ISSUE | md_start is out; unit samples it at end of this cycle
//  S_MD_WAIT  | shadow counter runs against md_busy until the unit drops busy
module muldiv_issue_ctrl #(
  parameter int W       = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ex_valid,
  input  logic [3:0]   i_ex_op,
  input  logic [W-1:0] i_ex_rs,
  input  logic [W-1:0] i_ex_rt,
  input  logic         i_flush,
  input  logic         i_md_busy,
  input  logic [W-1:0] i_md_hi,
  input  logic [W-1:0] i_md_lo,
  output logic [W-1:0] o_md_a,
  output logic [W-1:0] o_md_b,
  output logic         o_md_start,
  output logic         o_md_we,
  output logic         o_md_hilo,
  output logic [1:0]   o_md_mulop,
  output logic         o_stall,
  output logic         o_mf_valid,
  output logic [W-1:0] o_mf_data,
  output logic         o_err
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(LAT_MAX + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

  localparam logic [3:0] OP_MTHI = 4'd5;
  localparam logic [3:0] OP_MFHI = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MT       = 2'd1,
    S_MD_ISSUE = 2'd2,
    S_MD_WAIT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          r_start;
  logic          w_start_nxt;
  logic          r_we;
  logic          w_we_nxt;
  logic          r_mf_valid;
  logic          w_mf_valid_nxt;
  logic [W-1:0]  r_md_a;
  logic [W-1:0]  r_md_b;
  logic          r_md_hilo;
  logic [1:0]    r_md_mulop;
  logic [W-1:0]  r_mf_data;

  logic w_hilo_op;
  logic w_is_md;
  logic w_is_mt;
  logic w_is_mf;
  logic w_req;
  logic w_idle;
  logic w_accept;

  assign w_hilo_op = (i_ex_op >= 4'd1) && (i_ex_op <= 4'd8);
  assign w_is_md   = (i_ex_op >= 4'd1) && (i_ex_op <= 4'd4);
  assign w_is_mt   = (i_ex_op == 4'd5) || (i_ex_op == 4'd6);
  assign w_is_mf   = (i_ex_op == 4'd7) || (i_ex_op == 4'd8);
  assign w_req     = i_ex_valid & ~i_flush & w_hilo_op;
  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_req & w_idle;
  assign o_stall   = w_req & ~w_idle;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_start    <= 1'b0;
      r_we       <= 1'b0;
      r_mf_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_err      <= w_err_nxt;
      r_start    <= w_start_nxt;
      r_we       <= w_we_nxt;
      r_mf_valid <= w_mf_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_err_nxt      = r_err;
    w_start_nxt    = 1'b0;
    w_we_nxt       = 1'b0;
    w_mf_valid_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_md) begin
            w_start_nxt = 1'b1;
            w_state_nxt = S_MD_ISSUE;
          end else if (w_is_mt) begin
            w_we_nxt    = 1'b1;
            w_state_nxt = S_MT;
          end else begin
            w_mf_valid_nxt = 1'b1;
          end
        end
      end
      S_MT: begin
        w_state_nxt = S_IDLE;
      end
      S_MD_ISSUE: begin
        w_state_nxt = S_MD_WAIT;
        w_cnt_nxt   = r_md_mulop[1] ? DIV_CNT : MUL_CNT;
      end
      S_MD_WAIT: begin
        // Busy must last exactly the loaded latency; any other length is flagged.
        if (i_md_busy) begin
          if (r_cnt == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end else begin
          if (r_cnt != '0) begin
            w_err_nxt = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_md_a     <= '0;
      r_md_b     <= '0;
      r_md_hilo  <= 1'b0;
      r_md_mulop <= 2'b00;
      r_mf_data  <= '0;
    end else if (w_accept) begin
      if (w_is_md) begin
        r_md_a     <= i_ex_rs;
        r_md_b     <= i_ex_rt;
        r_md_mulop <= 2'(i_ex_op - 4'd1);
      end else if (w_is_mt) begin
        r_md_a    <= i_ex_rs;
        r_md_hilo <= (i_ex_op == OP_MTHI);
      end else if (w_is_mf) begin
        r_mf_data <= (i_ex_op == OP_MFHI) ? i_md_hi : i_md_lo;
      end
    end
  end

  assign o_md_a     = r_md_a;
  assign o_md_b     = r_md_b;
  assign o_md_start = r_start;
  assign o_md_we    = r_we;
  assign o_md_hilo  = r_md_hilo;
  assign o_md_mulop = r_md_mulop;
  assign o_mf_valid = r_mf_valid;
  assign o_mf_data  = r_mf_data;
  assign o_err      = r_err;

`ifndef SYNTHESIS
  a_one_cmd: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(r_start && r_we));
`endif

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: behavioural mul/div unit plus a cycle-indexed model
// of the controller's issue/stall/error rules, compared on every falling edge.
module tb_muldiv_issue_ctrl;

  localparam int W       = 32;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  localparam logic [3:0] MULTU = 4'd1, MULT = 4'd2, DIVU = 4'd3, DIV = 4'd4;
  localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ex_valid = 1'b0;
  logic [3:0]   ex_op = 4'd0;
  logic [W-1:0] ex_rs = '0;
  logic [W-1:0] ex_rt = '0;
  logic         flush = 1'b0;
  logic         md_busy;
  logic [W-1:0] md_hi, md_lo;
  logic [W-1:0] o_md_a, o_md_b, o_mf_data;
  logic         o_md_start, o_md_we, o_md_hilo, o_stall, o_mf_valid, o_err;
  logic [1:0]   o_md_mulop;

  int n_tot = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int busy_mode = 0;   // 0 nominal, 1 busy drops early, 2 busy stuck high

  always #5 clk = ~clk;

  muldiv_issue_ctrl #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_ex_valid(ex_valid), .i_ex_op(ex_op),
    .i_ex_rs(ex_rs), .i_ex_rt(ex_rt), .i_flush(flush), .i_md_busy(md_busy),
    .i_md_hi(md_hi), .i_md_lo(md_lo), .o_md_a(o_md_a), .o_md_b(o_md_b),
    .o_md_start(o_md_start), .o_md_we(o_md_we), .o_md_hilo(o_md_hilo),
    .o_md_mulop(o_md_mulop), .o_stall(o_stall), .o_mf_valid(o_mf_valid),
    .o_mf_data(o_mf_data), .o_err(o_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // mul/div unit stand-in
  int           u_cnt = 0;
  logic [W-1:0] u_hi = '0, u_lo = '0, u_phi = '0, u_plo = '0;
  assign md_busy = (u_cnt != 0);
  assign md_hi   = u_hi;
  assign md_lo   = u_lo;

  // controller model: expected registered outputs plus occupancy bookkeeping
  int           cyc = 0;
  int           m_hold_until = 0;
  bit           m_await = 1'b0;
  int           m_seen = 0;
  int           m_lat = 0;
  logic         e_start = 0, e_we = 0, e_mfv = 0, e_hilo = 0, e_err = 0;
  logic [1:0]   e_mulop = 0;
  logic [W-1:0] e_a = '0, e_b = '0, e_mfd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_start = 0; e_we = 0; e_mfv = 0; e_hilo = 0; e_err = 0;
      e_mulop = 0; e_a = '0; e_b = '0; e_mfd = '0;
      m_hold_until = 0; m_await = 0; m_seen = 0;
      u_cnt <= 0; u_hi <= '0; u_lo <= '0; u_phi <= '0; u_plo <= '0;
    end else begin
      bit occ, req;
      logic [63:0] p;
      logic signed [63:0] sa, sb;
      occ = (cyc < m_hold_until) || m_await;
      req = ex_valid && !flush && (ex_op >= 4'd1) && (ex_op <= 4'd8);
      e_start = 0; e_we = 0; e_mfv = 0;
      if (m_await && cyc >= m_hold_until) begin
        if (md_busy) begin
          m_seen++;
          if (m_seen > m_lat) e_err = 1;
        end else begin
          if (m_seen != m_lat) e_err = 1;
          m_await = 0;
        end
      end
      if (req && !occ) begin
        if (ex_op <= 4'd4) begin
          e_start = 1; e_a = ex_rs; e_b = ex_rt; e_mulop = 2'(ex_op - 4'd1);
          m_hold_until = cyc + 2; m_await = 1; m_seen = 0;
          m_lat = (ex_op >= DIVU) ? DIV_LAT : MUL_LAT;
        end else if (ex_op <= 4'd6) begin
          e_we = 1; e_a = ex_rs; e_hilo = (ex_op == MTHI);
          m_hold_until = cyc + 2;
        end else begin
          e_mfv = 1; e_mfd = (ex_op == MFHI) ? u_hi : u_lo;
        end
      end
      // unit responds to the commands the DUT actually drives
      if (o_md_we) begin
        if (o_md_hilo) u_hi <= o_md_a; else u_lo <= o_md_a;
      end
      if (o_md_start) begin
        sa = $signed(o_md_a);
        sb = $signed(o_md_b);
        case (o_md_mulop)
          2'b00: begin p = {32'd0, o_md_a} * {32'd0, o_md_b}; u_phi <= p[63:32]; u_plo <= p[31:0]; end
          2'b01: begin p = sa * sb; u_phi <= p[63:32]; u_plo <= p[31:0]; end
          2'b10: begin u_plo <= o_md_a / o_md_b; u_phi <= o_md_a % o_md_b; end
          default: begin u_plo <= $signed(o_md_a) / $signed(o_md_b); u_phi <= $signed(o_md_a) % $signed(o_md_b); end
        endcase
        u_cnt <= (busy_mode == 2) ? 1 : (busy_mode == 1) ? 3 : (o_md_mulop[1] ? DIV_LAT : MUL_LAT);
      end else if (u_cnt != 0 && busy_mode != 2) begin
        u_cnt <= u_cnt - 1;
        if (u_cnt == 1) begin
          u_hi <= u_phi;
          u_lo <= u_plo;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_stall;
      e_stall = ex_valid && !flush && (ex_op >= 4'd1) && (ex_op <= 4'd8) &&
                ((cyc < m_hold_until) || m_await);
      chk("stall", 32'(o_stall), 32'(e_stall));
      chk("md_start", 32'(o_md_start), 32'(e_start));
      chk("md_we", 32'(o_md_we), 32'(e_we));
      chk("mf_valid", 32'(o_mf_valid), 32'(e_mfv));
      chk("err", 32'(o_err), 32'(e_err));
      chk("md_a", o_md_a, e_a);
      chk("md_b", o_md_b, e_b);
      chk("md_mulop", 32'(o_md_mulop), 32'(e_mulop));
      chk("md_hilo", 32'(o_md_hilo), 32'(e_hilo));
      if (e_mfv) chk("mf_data", o_mf_data, e_mfd);
    end
  end

  // Present one instruction until it is accepted (or flushed); returns stall count.
  task automatic send(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt,
                      input bit fl, output int stalls);
    bit done;
    ex_valid = 1; ex_op = op; ex_rs = rs; ex_rt = rt; flush = fl;
    stalls = 0; done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!o_stall) begin
        done = 1;
        break;
      end
      stalls++;
    end
    if (!done) begin
      n_tot++; n_bad++;
      $display("FAIL send_timeout: op %0d still stalled after 200 cycles", op);
    end
    @(posedge clk); #2;
    ex_valid = 0; ex_op = 4'd0; flush = 0;
  endtask

  task automatic mf_expect(input logic [3:0] op, input logic [W-1:0] lit, input string nm);
    int st;
    send(op, '0, '0, 0, st);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(o_mf_valid), 32'd1);
    chk(nm, o_mf_data, lit);
    @(posedge clk); #2;
  endtask

  initial begin
    int st;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_start", 32'(o_md_start), 0);
    chk("rst_we", 32'(o_md_we), 0);
    chk("rst_mfv", 32'(o_mf_valid), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_md_a", o_md_a, 0);
    @(negedge clk); #2;
    rst_n = 1; chk_en = 1;
    @(posedge clk); #2;

    send(MULT, 32'hFFFF_FFFE, 32'd3, 0, st);
    @(negedge clk);
    chk("mult_start", 32'(o_md_start), 1);
    chk("mult_mulop", 32'(o_md_mulop), 1);
    @(posedge clk); #2;
    mf_expect(MFLO, 32'hFFFF_FFFA, "mult_lo");
    mf_expect(MFHI, 32'hFFFF_FFFF, "mult_hi");
    chk("mult_err", 32'(o_err), 0);

    send(DIVU, 32'd100, 32'd7, 0, st);
    mf_expect(MFHI, 32'd2, "divu_hi");
    mf_expect(MFLO, 32'd14, "divu_lo");

    send(MTHI, 32'h1234_5678, '0, 0, st);
    send(MFHI, '0, '0, 0, st);
    chk("mt_mf_stalls", st, 1);
    @(negedge clk);
    chk("mthi_data", o_mf_data, 32'h1234_5678);
    @(posedge clk); #2;

    send(MULT, 32'd5, 32'd5, 1, st);
    @(negedge clk);
    chk("flush_no_start", 32'(o_md_start), 0);
    @(posedge clk); #2;
    send(MFLO, '0, '0, 0, st);
    chk("flush_no_stall", st, 0);
    @(negedge clk);
    chk("flush_lo", o_mf_data, 32'd14);
    @(posedge clk); #2;

    send(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, st);
    mf_expect(MFHI, 32'hFFFF_FFFE, "multu_hi");
    send(DIV, 32'hFFFF_FF9C, 32'd7, 0, st);
    mf_expect(MFLO, 32'hFFFF_FFF2, "div_lo");
    mf_expect(MFHI, 32'hFFFF_FFFE, "div_hi");
    send(MTLO, 32'hA5A5_A5A5, '0, 0, st);
    mf_expect(MFLO, 32'hA5A5_A5A5, "mtlo_data");

    // flushed ops during the wait must neither stall nor cancel the multiply
    send(MULT, 32'd7, 32'd6, 0, st);
    ex_valid = 1; ex_op = MFLO; flush = 1;
    repeat (3) @(posedge clk);
    #2; ex_valid = 0; flush = 0; ex_op = 4'd0;
    mf_expect(MFLO, 32'd42, "flush_wait_lo");
    chk("nominal_err", 32'(o_err), 0);

    busy_mode = 1;
    send(MULT, 32'd2, 32'd3, 0, st);
    send(MFLO, '0, '0, 0, st);
    @(negedge clk);
    chk("short_busy_err", 32'(o_err), 1);
    busy_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    mf_expect(MFHI, 32'd0, "short_busy_idle");
    chk("err_sticky", 32'(o_err), 1);

    @(negedge clk); #2;
    rst_n = 0;
    #1 chk("err_rst_clear", 32'(o_err), 0);
    @(negedge clk); #2;
    rst_n = 1;
    @(posedge clk); #2;

    busy_mode = 2;
    send(MULT, 32'd3, 32'd3, 0, st);
    repeat (12) @(posedge clk);
    #2; ex_valid = 1; ex_op = MFLO;
    @(negedge clk);
    chk("stuck_stall", 32'(o_stall), 1);
    chk("stuck_err", 32'(o_err), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_stall", 32'(o_stall), 0);
    chk("arst_start", 32'(o_md_start), 0);
    chk("arst_we", 32'(o_md_we), 0);
    chk("arst_mfv", 32'(o_mf_valid), 0);
    chk("arst_err", 32'(o_err), 0);
    ex_valid = 0; ex_op = 4'd0; busy_mode = 0;
    @(negedge clk); #2;
    rst_n = 1;
    @(posedge clk); #2;
    send(MULT, 32'd9, 32'd9, 0, st);
    @(negedge clk);
    chk("post_rst_start", 32'(o_md_start), 1);
    @(posedge clk); #2;
    mf_expect(MFLO, 32'd81, "post_rst_lo");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $display("test done: total=%0d bad=%0d", n_tot, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
